stack_merge_clear: RTL and testbench
====================================

# stack_merge_clear

Playfield stack register and line-clear engine. It sits directly downstream of the falling-piece stage. When the piece lands, this block ORs the piece bitmap into the stored stack. It then scans every row bottom-to-top, removes full rows, shifts the rows above down, and reports the lines cleared, a running line total and an optional score. Its `stack_array` output feeds collision checking and the display compositor.

## Interface
Parameters:
- `ROWS`, 22: playfield rows. Row 0 is the top; rows 0–1 are hidden spawn rows.
- `COLS`, 10: playfield columns.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `piece_array`, input, [ROWS-1:0][COLS-1:0]: bitmap of the landed piece, indexed [row][col].
- `land`, input, 1: commit `piece_array`. Sampled only in IDLE.
- `clear_stack`, input, 1: synchronous clear of the whole block. Highest priority.
- `stack_array`, output, [ROWS-1:0][COLS-1:0]: registered stack.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of each commit.
- `lines_cleared`, output, 3: rows removed by the last commit (0–4). Held until the next `done`.
- `total_lines`, output, 10: cumulative cleared rows. Saturates at 1023.
- `score`, output, 14: cumulative score. Saturates at 16383. Tied to 0 without the macro.
- `game_over`, output, 1: sticky overflow flag.

## Operation
- State machine with three states: IDLE, SCAN, DONE.
- **IDLE**
  - If `land` is high and `game_over` is low: `stack <= stack | piece_array`, row pointer `r <= ROWS-1`, `cnt <= 0`, go to SCAN.
  - `land` with `game_over` high is ignored.
- **SCAN** (one row evaluated per cycle):
  - If `stack[r]` is all ones:
    - Every row i in 1..r takes row i-1; row 0 becomes 0.
    - `cnt <= cnt + 1`; `r` stays the same, so the row shifted into `r` is re-checked.
  - Otherwise:
    - If `r == 0`, go to DONE.
    - Else `r <= r - 1`.
- **DONE** (one cycle):
  - `done = 1`; `lines_cleared <= cnt`.
  - `total_lines` += `cnt` (saturating); `score` updates as described under Configuration.
  - `game_over` is set if any bit in rows 0–1 is set.
  - Next state is IDLE.
- Pieces overlapping occupied cells are ORed in without error; overlap prevention is the upstream stage's responsibility.
- `land` asserted during SCAN or DONE is dropped. No queueing.
- `clear_stack`, in any state, at the next edge:
  - zeroes the stack, `lines_cleared`, `total_lines`, `score` and `game_over`;
  - returns to IDLE;
  - takes precedence over a simultaneous `land`.
- `cnt` cannot exceed 4 for legal pieces. It is 3 bits wide and saturates at 7.

## Timing
- Reset values:
  - `stack_array` = 0, `lines_cleared` = 0, `total_lines` = 0, `score` = 0;
  - `busy` = 0, `done` = 0, `game_over` = 0;
  - state = IDLE.
- `land` is sampled high at edge E0, the end of cycle t:
  - the merged stack is visible in cycle t+1;
  - `busy` is high from t+1 through the DONE cycle.
- With k rows cleared, `done` is high in cycle t+23+k. That is 22 row evaluations, plus k shift cycles, plus 1.
- `lines_cleared`, `total_lines`, `score` and `game_over` become visible in the cycle after `done`.
- The earliest next accepted `land` is the cycle after `done`.
- `stack_array` changes only on the merge edge, on shift edges and on `clear_stack`. It is stable in all other cycles.
- If `rst_n` is asserted mid-SCAN, all state clears immediately and no `done` is produced.

## Configuration
- `STACK_MERGE_CLEAR_SCORE_EN` defined:
  - the score accumulator is built;
  - in DONE, `score` += 0, 40, 100, 300 or 1200 for `cnt` = 0, 1, 2, 3 or 4;
  - `cnt` values above 4 score 1200;
  - the sum saturates at 16383.
- Not defined: the `score` port exists but is tied to 0, and no accumulator logic is synthesized.

## Test plan
- **Reset:** hold `rst_n` low, then release.
  - All outputs 0, `busy` = 0.
  - `land` in the first cycle after release is accepted.
- **Empty stack, vertical I-piece:** `piece_array` has column 4 set in rows 16–19; pulse `land` at cycle t.
  - `stack_array` rows 16–19 equal 10'h010 from t+1.
  - `done` at t+23, `lines_cleared` = 0, `total_lines` = 0.
- **Single clear:** preload row 21 = 10'h3EF by landing it, then land column 4 in rows 18–21.
  - `done` at t+24, `lines_cleared` = 1.
  - Final rows 19–21 = 10'h010, row 18 = 0.
  - `score` = 40 with the macro, 0 without.
- **Tetris:** preload rows 18–21 = 10'h3EF, then land column 4 in rows 18–21.
  - `done` at t+27, `lines_cleared` = 4, `stack_array` = 0.
  - `score` = 1200 with the macro; `total_lines` = 4.
- **Busy and clear:** pulse `land` during SCAN, then assert `clear_stack` at cycle t+10.
  - The second `land` is ignored.
  - At t+11: state IDLE, `stack_array` = 0, `busy` = 0, no `done` pulse.
- **Game over:** land a piece occupying row 1, column 5.
  - `game_over` = 1 after `done`.
  - A subsequent `land` leaves the stack unchanged and `busy` stays 0.
  - `clear_stack` clears `game_over`.

Source files
------------

// File: rtl/stack_merge_clear.sv
// Playfield stack register with piece merge and bottom-up line-clear scan.
// Optional score accumulator: define STACK_MERGE_CLEAR_SCORE_EN.

module stack_merge_clear_row #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] above,
  input  logic            shift,
  output logic [COLS-1:0] nxt,
  output logic            full
);
  assign nxt  = shift ? above : cur;
  assign full = &cur;
endmodule

module stack_merge_clear #(
  parameter int ROWS = 22,
  parameter int COLS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ROWS-1:0][COLS-1:0] piece_array,
  input  logic                      land,
  input  logic                      clear_stack,
  output logic [ROWS-1:0][COLS-1:0] stack_array,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                lines_cleared,
  output logic [9:0]                total_lines,
  output logic [13:0]               score,
  output logic                      game_over
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [ROWS-1:0][COLS-1:0] stack, above, shifted;
  logic [ROWS-1:0]           full;
  logic [RW-1:0]             r;
  logic [2:0]                cnt;
  logic                      scan_full;
  logic [10:0]               tsum;

  assign scan_full = (state == SCAN) && full[r];

  // Each row either holds or takes the row above it; rows at or above r shift on a clear.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    if (i == 0) begin : g_top
      assign above[i] = '0;
    end else begin : g_mid
      assign above[i] = stack[i-1];
    end
    stack_merge_clear_row #(.COLS(COLS)) u_row (
      .cur  (stack[i]),
      .above(above[i]),
      .shift(scan_full && (RW'(i) <= r)),
      .nxt  (shifted[i]),
      .full (full[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (land && !game_over) state_nxt = SCAN;
      SCAN:    if (!full[r] && r == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_stack) state_nxt = IDLE;
  end

  assign tsum = {1'b0, total_lines} + {8'b0, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      stack         <= '0;
      r             <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      game_over     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear_stack) begin
        stack         <= '0;
        r             <= '0;
        cnt           <= '0;
        lines_cleared <= '0;
        total_lines   <= '0;
        game_over     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (land && !game_over) begin
            stack <= stack | piece_array;
            r     <= RW'(ROWS-1);
            cnt   <= '0;
          end
          SCAN: if (full[r]) begin
            // r holds so the row dropped into it gets re-evaluated
            stack <= shifted;
            if (cnt != 3'd7) cnt <= cnt + 3'd1;
          end else if (r != '0) begin
            r <= r - RW'(1);
          end
          DONE: begin
            lines_cleared <= cnt;
            total_lines   <= tsum[10] ? 10'h3FF : tsum[9:0];
            game_over     <= game_over | (|stack[0]) | (|stack[1]);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STACK_MERGE_CLEAR_SCORE_EN
  logic [13:0] score_q;
  logic [10:0] pts;
  logic [14:0] ssum;

  always_comb begin
    pts = '0;
    case (cnt)
      3'd0:    pts = 11'd0;
      3'd1:    pts = 11'd40;
      3'd2:    pts = 11'd100;
      3'd3:    pts = 11'd300;
      default: pts = 11'd1200;
    endcase
  end

  assign ssum = {1'b0, score_q} + {4'b0, pts};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              score_q <= '0;
    else if (clear_stack)    score_q <= '0;
    else if (state == DONE)  score_q <= ssum[14] ? 14'h3FFF : ssum[13:0];
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign stack_array = stack;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
endmodule

// File: tb/tb_stack_merge_clear.sv
// Randomized bench for stack_merge_clear against a commit-level model plus directed literal checks.
module tb_stack_merge_clear;
  localparam int ROWS = 22;
  localparam int COLS = 10;
  typedef logic [ROWS-1:0][COLS-1:0] stk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  stk_t        piece_array = '0;
  logic        land = 1'b0;
  logic        clear_stack = 1'b0;
  stk_t        stack_array;
  logic        busy, done, game_over;
  logic [2:0]  lines_cleared;
  logic [9:0]  total_lines;
  logic [13:0] score;

  stack_merge_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .piece_array(piece_array), .land(land),
    .clear_stack(clear_stack), .stack_array(stack_array), .busy(busy),
    .done(done), .lines_cleared(lines_cleared), .total_lines(total_lines),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: a commit removes every full row at once and compacts the rest downward.
  function automatic stk_t collapse(input stk_t s);
    stk_t o = '0;
    int w = ROWS - 1;
    for (int i = ROWS - 1; i >= 0; i--)
      if (s[i] != '1) begin o[w] = s[i]; w--; end
    return o;
  endfunction

  function automatic int nfull(input stk_t s);
    int n = 0;
    for (int i = 0; i < ROWS; i++) if (s[i] == '1) n++;
    return n;
  endfunction

  function automatic int sat7(input int k);
    return (k > 7) ? 7 : k;
  endfunction

  function automatic int pts(input int k);
    case (k)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  function automatic int smin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  stk_t m_stack, m_merged;
  int   m_k, m_t, m_done_c, m_lines, m_total, m_score;
  bit   m_busy, m_go;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stack <= '0; m_merged <= '0; m_busy <= 1'b0; m_go <= 1'b0;
      m_lines <= 0; m_total <= 0; m_score <= 0; m_k <= 0; m_t <= -10; m_done_c <= -10;
    end else if (clear_stack) begin
      m_stack <= '0; m_busy <= 1'b0; m_go <= 1'b0;
      m_lines <= 0; m_total <= 0; m_score <= 0;
    end else if (m_busy) begin
      if (cyc == m_done_c) begin
        m_busy  <= 1'b0;
        m_lines <= sat7(m_k);
        m_total <= smin(m_total + sat7(m_k), 1023);
        m_score <= smin(m_score + pts(sat7(m_k)), 16383);
        m_go    <= m_go | (|m_stack[0]) | (|m_stack[1]);
      end
    end else if (land && !m_go) begin
      m_busy   <= 1'b1;
      m_merged <= m_stack | piece_array;
      m_stack  <= collapse(m_stack | piece_array);
      m_k      <= nfull(m_stack | piece_array);
      m_t      <= cyc;
      m_done_c <= cyc + 23 + nfull(m_stack | piece_array);
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_busy && (cyc == m_done_c));
    if (!m_busy)                  check("stack_idle", stack_array, m_stack);
    else if (cyc == m_t + 1)      check("stack_merged", stack_array, m_merged);
    else if (cyc == m_done_c)     check("stack_done", stack_array, m_stack);
    check("lines_cleared", lines_cleared, m_lines);
    check("total_lines", total_lines, m_total);
`ifdef STACK_MERGE_CLEAR_SCORE_EN
    check("score", score, m_score);
`else
    check("score", score, 0);
`endif
    check("game_over", game_over, m_go);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_clear;
    clear_stack = 1'b1; tick; clear_stack = 1'b0;
  endtask

  task automatic land_wait(input stk_t p, output int lat, output stk_t snap);
    int t;
    t = cyc;
    piece_array = p; land = 1'b1;
    tick;
    land = 1'b0; piece_array = '0;
    snap = stack_array;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t; break; end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    tick;
  endtask

  function automatic stk_t col4(input int lo, input int hi);
    stk_t p = '0;
    for (int i = lo; i <= hi; i++) p[i] = 10'h010;
    return p;
  endfunction

  function automatic stk_t gen_piece();
    stk_t p = '0;
    for (int i = 2; i < ROWS; i++)
      if ($urandom_range(0, 5) == 0)
        p[i] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 24) == 0) p[1][$urandom_range(0, 9)] = 1'b1;
    return p;
  endfunction

  initial begin
    int   lat;
    int   t;
    stk_t snap, p;

    repeat (3) tick;
    check("reset_busy", busy, 0);
    check("reset_stack", stack_array, 0);
    check("reset_total", total_lines, 0);
    rst_n = 1'b1;

    // I-piece on empty stack, landed in the first cycle after reset release
    land_wait(col4(16, 19), lat, snap);
    check("i_latency", lat, 23);
    check("i_row16", snap[16], 10'h010);
    check("i_row19", snap[19], 10'h010);
    check("i_lines", lines_cleared, 0);
    check("i_total", total_lines, 0);

    do_clear;
    p = '0; p[21] = 10'h3EF;
    land_wait(p, lat, snap);
    land_wait(col4(18, 21), lat, snap);
    check("single_latency", lat, 24);
    check("single_lines", lines_cleared, 1);
    check("single_row21", stack_array[21], 10'h010);
    check("single_row19", stack_array[19], 10'h010);
    check("single_row18", stack_array[18], 10'h000);
`ifdef STACK_MERGE_CLEAR_SCORE_EN
    check("single_score", score, 40);
`else
    check("single_score", score, 0);
`endif

    do_clear;
    p = '0; for (int i = 18; i < 22; i++) p[i] = 10'h3EF;
    land_wait(p, lat, snap);
    land_wait(col4(18, 21), lat, snap);
    check("tetris_latency", lat, 27);
    check("tetris_lines", lines_cleared, 4);
    check("tetris_stack", stack_array, 0);
    check("tetris_total", total_lines, 4);
`ifdef STACK_MERGE_CLEAR_SCORE_EN
    check("tetris_score", score, 1200);
`endif

    // land during SCAN is dropped, clear_stack aborts the scan
    do_clear;
    t = cyc;
    piece_array = col4(16, 19); land = 1'b1; tick; land = 1'b0;
    while (cyc < t + 5) tick;
    piece_array = col4(10, 13); land = 1'b1; tick; land = 1'b0; piece_array = '0;
    while (cyc < t + 10) tick;
    clear_stack = 1'b1; tick; clear_stack = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_stack", stack_array, 0);
    check("abort_done", done, 0);
    repeat (30) begin tick; check("abort_no_done", done, 0); end

    // async reset mid-scan
    piece_array = col4(16, 19); land = 1'b1; tick; land = 1'b0; piece_array = '0;
    repeat (5) tick;
    rst_n = 1'b0; #1;
    check("rst_busy", busy, 0);
    check("rst_stack", stack_array, 0);
    tick; rst_n = 1'b1;

    p = '0; p[1] = 10'h020;
    land_wait(p, lat, snap);
    check("go_flag", game_over, 1);
    snap = stack_array;
    piece_array = col4(16, 19); land = 1'b1; tick; land = 1'b0; piece_array = '0;
    check("go_busy", busy, 0);
    tick;
    check("go_stack", stack_array, snap);
    do_clear;
    check("go_cleared", game_over, 0);

    for (int i = 0; i < 4000; i++) begin
      piece_array = gen_piece();
      land = ($urandom_range(0, 7) == 0);
      clear_stack = ($urandom_range(0, 299) == 0);
      tick;
    end
    land = 1'b0; clear_stack = 1'b0; piece_array = '0;
    repeat (60) tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
